// File: rtl/lcd_text_arbiter_pkg.sv
// Shared LCD text-frame constants and arbiter types.
// Optional build macro: LCD_ARB_PREEMPT_EN (alarm channel 0 preempts).
package lcd_text_arbiter_pkg;

    localparam int          LCD_FRAME_W     = 256;
    localparam int          LCD_CHAR_W      = 8;
    localparam logic [7:0]  LCD_BLANK       = 8'h20;
    localparam int          LCD_REFRESH_CYC = 68034;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lcd_text_arbiter_if.sv
// Requester/arbiter/driver bundle for the shared text-LCD frame buffer.
// master = requester side, slave = arbiter side.
interface lcd_text_arbiter_if
    import lcd_text_arbiter_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int IDXW = idx_w(NREQ);

    logic [NREQ-1:0]             req;
    logic [NREQ*LCD_FRAME_W-1:0] frame;
    logic [NREQ-1:0]             ack;
    logic [NREQ-1:0]             done;
    logic [LCD_FRAME_W-1:0]      data;
    logic [IDXW-1:0]             owner;
    logic                        busy;

    modport master (
        output req, frame,
        input  ack, done, data, owner, busy
    );

    modport slave (
        input  req, frame,
        output ack, done, data, owner, busy
    );

endinterface

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: first set req bit after last, with wrap.
module lcd_rr_pick
    import lcd_text_arbiter_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDXW = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] last_i,
    output logic [IDXW-1:0] grant_o,
    output logic            valid_o
);

    int idx;

    // Walk offsets from far to near so the nearest hit is written last.
    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        idx     = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last_i) + k) % NREQ;
            if (req_i[idx]) begin
                grant_o = IDXW'(idx);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_text_arbiter.sv
// Round-robin arbiter sharing the 2x16 text LCD frame among NREQ requesters.
// Optional build macro: LCD_ARB_PREEMPT_EN (requester 0 preempts any hold).
module lcd_text_arbiter
    import lcd_text_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DWELL_CYC = LCD_REFRESH_CYC,
    parameter int DWELL_W   = 17,
    parameter logic [LCD_FRAME_W-1:0] DEFAULT_FRAME =
        {(LCD_FRAME_W / LCD_CHAR_W){LCD_BLANK}}
) (
    input logic               LCDCLK,
    input logic               PRESET,
    lcd_text_arbiter_if.slave bus
);

    localparam int IDXW = idx_w(NREQ);
    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL_CYC - 1);
    localparam logic [IDXW-1:0]    LAST_RST = IDXW'(NREQ - 1);

    arb_state_e             state_q, state_d;
    logic [DWELL_W-1:0]     cnt_q, cnt_d;
    logic [IDXW-1:0]        last_q, last_d;
    logic [IDXW-1:0]        owner_q, owner_d;
    logic [LCD_FRAME_W-1:0] data_q, data_d;
    logic [NREQ-1:0]        ack_q, ack_d;
    logic [NREQ-1:0]        done_q, done_d;
    logic                   busy_q, busy_d;

    logic [IDXW-1:0]        pick_idx;
    logic                   pick_vld;

    lcd_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req_i   (bus.req),
        .last_i  (last_q),
        .grant_o (pick_idx),
        .valid_o (pick_vld)
    );

    always_ff @(posedge LCDCLK) begin
        if (PRESET) begin
            state_q <= ARB_IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
            data_q  <= DEFAULT_FRAME;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        data_d  = data_q;
        ack_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_vld) begin
                    data_d = bus.frame[int'(pick_idx)*LCD_FRAME_W +: LCD_FRAME_W];
                    owner_d         = pick_idx;
                    ack_d[pick_idx] = 1'b1;
                    cnt_d           = '0;
                    busy_d          = 1'b1;
                    state_d         = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    done_d[owner_q] = 1'b1;
                    last_d          = owner_q;
                    cnt_d           = '0;
                    busy_d          = 1'b0;
                    state_d         = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
`ifdef LCD_ARB_PREEMPT_EN
                // Alarm takeover: last untouched so the victim keeps its turn.
                if (bus.req[0] && (owner_q != '0)) begin
                    done_d          = '0;
                    done_d[owner_q] = 1'b1;
                    ack_d[0]        = 1'b1;
                    data_d          = bus.frame[0 +: LCD_FRAME_W];
                    owner_d         = '0;
                    cnt_d           = '0;
                    last_d          = last_q;
                    busy_d          = 1'b1;
                    state_d         = ARB_HOLD;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.ack   = ack_q;
    assign bus.done  = done_q;
    assign bus.data  = data_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Bench for lcd_text_arbiter: directed scenarios plus random traffic,
// every cycle compared against a dwell-countdown reference model.
module tb_lcd_text_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam logic [255:0] BLANK = {32{8'h20}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [255:0] frm [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    lcd_text_arbiter_if #(.NREQ(N)) bus ();

    assign bus.req   = req;
    assign bus.frame = {frm[3], frm[2], frm[1], frm[0]};

    lcd_text_arbiter #(
        .NREQ      (N),
        .DWELL_CYC (DW),
        .DWELL_W   (4)
    ) dut (
        .LCDCLK (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a grant shows the frame for DW cycles, then one idle.
    bit           m_ok = 1'b0;
    bit           m_hold;
    int           m_left, m_owner, m_last;
    logic [255:0] m_data;
    logic [N-1:0] m_ack, m_done;
    bit           m_pre, m_found;
    int           m_g;

    always @(posedge clk) begin
        cyc++;
        m_ack  = '0;
        m_done = '0;
        if (rst) begin
            m_hold  = 1'b0;
            m_left  = 0;
            m_owner = 0;
            m_last  = N - 1;
            m_data  = BLANK;
            m_ok    = 1'b1;
        end else if (m_hold) begin
            m_pre = 1'b0;
`ifdef LCD_ARB_PREEMPT_EN
            m_pre = req[0] && (m_owner != 0);
`endif
            if (m_pre) begin
                m_done[m_owner] = 1'b1;
                m_ack[0] = 1'b1;
                m_data   = frm[0];
                m_owner  = 0;
                m_left   = DW;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done[m_owner] = 1'b1;
                    m_last = m_owner;
                    m_hold = 1'b0;
                end
            end
        end else if (req != '0) begin
            m_found = 1'b0;
            m_g     = 0;
            for (int k = 1; k <= N; k++) begin
                if (!m_found && req[(m_last + k) % N]) begin
                    m_g     = (m_last + k) % N;
                    m_found = 1'b1;
                end
            end
            m_ack[m_g] = 1'b1;
            m_data  = frm[m_g];
            m_owner = m_g;
            m_left  = DW;
            m_hold  = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("ack",   bus.ack,   m_ack);
            chk("done",  bus.done,  m_done);
            chk("data",  bus.data,  m_data);
            chk("owner", bus.owner, m_owner);
            chk("busy",  bus.busy,  m_hold);
        end
    end

    task automatic wait_ack(output int idx, output int c);
        bit seen;
        seen = 1'b0;
        idx  = -1;
        c    = 0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                seen = 1'b1;
                c    = cyc;
                for (int i = 0; i < N; i++)
                    if (bus.ack[i]) idx = i;
            end
        end
        if (!seen) chk("ack_timeout", 0, 1);
    endtask

    task automatic rand_frame(input int i);
        frm[i] = {$urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int           idx, c, prev;
    int           order [5] = '{0, 1, 2, 3, 0};
    logic [255:0] old;

    initial begin
        for (int i = 0; i < N; i++) rand_frame(i);
        repeat (2) @(negedge clk);

        // Reset values and a single grant to requester 1
        chk("rst_data",  bus.data,  BLANK);
        chk("rst_owner", bus.owner, 0);
        chk("rst_busy",  bus.busy,  0);
        chk("rst_ack",   bus.ack,   0);
        rst = 1'b0;
        req = 4'b0010;
        @(negedge clk);
        chk("s1_ack",  bus.ack,  4'b0010);
        chk("s1_data", bus.data, frm[1]);
        req = '0;
        repeat (8) @(negedge clk);
        chk("s1_done", bus.done, 4'b0010);
        chk("s1_busy", bus.busy, 0);

        // All requesting: rotation 0,1,2,3,0 spaced DW+1 apart
        pulse_reset();
        req  = 4'b1111;
        prev = 0;
        for (int j = 0; j < 5; j++) begin
            wait_ack(idx, c);
            chk("s2_order", idx, order[j]);
            if (idx >= 0) chk("s2_data", bus.data, frm[idx]);
            if (j > 0) chk("s2_gap", c - prev, DW + 1);
            prev = c;
        end
        req = '0;
        repeat (10) @(negedge clk);

        // Frame and req changes during a hold are ignored
        pulse_reset();
        req = 4'b0100;
        wait_ack(idx, c);
        chk("s3_idx", idx, 2);
        old = frm[2];
        frm[2] = ~frm[2];
        req = '0;
        repeat (7) begin
            @(negedge clk);
            chk("s3_data", bus.data, old);
        end
        @(negedge clk);
        chk("s3_done", bus.done, 4'b0100);
        rand_frame(2);

        // Reset in the middle of a hold
        pulse_reset();
        req = 4'b0010;
        wait_ack(idx, c);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        chk("s4_busy", bus.busy, 0);
        chk("s4_data", bus.data, BLANK);
        chk("s4_done", bus.done, 0);
        rst = 1'b0;
        req = 4'b0001;
        @(negedge clk);
        chk("s4_ack", bus.ack, 4'b0001);
        req = '0;
        repeat (10) @(negedge clk);

`ifdef LCD_ARB_PREEMPT_EN
        // Alarm channel takes over requester 3's hold
        pulse_reset();
        req = 4'b1000;
        wait_ack(idx, c);
        chk("s5_idx", idx, 3);
        repeat (3) @(negedge clk);
        req = 4'b1001;
        @(negedge clk);
        chk("s5_done", bus.done, 4'b1000);
        chk("s5_ack",  bus.ack,  4'b0001);
        chk("s5_data", bus.data, frm[0]);
        wait_ack(idx, c);
        chk("s5_next", idx, 3);
        req = '0;
        repeat (10) @(negedge clk);
`endif

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) rand_frame($urandom_range(0, N - 1));
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        req = '0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
